fmrv32im_axi_arbiter: RTL

FMRV32IM_AXI_ARBITER -- requirements
Module: fmrv32im_axi_arbiter

---
 rtl/fmrv32im_axi_arb_pkg.sv | 19 +
 rtl/fmrv32im_rr_arbiter.sv | 29 ++
 rtl/fmrv32im_axi_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fmrv32im_axi_arb_pkg.sv
// Shared types and AXI constants for the fmrv32im instruction/data AXI arbiter.
// Round-robin arbitration is enabled by defining FMRV32IM_AXI_ARB_RR_EN.
package fmrv32im_axi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WADDR,
    WRESP,
    DONE
  } state_t;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;

endpackage

// File: rtl/fmrv32im_rr_arbiter.sv
// Two-port grant selector, combinational, one-hot grant.
// FMRV32IM_AXI_ARB_RR_EN selects round-robin; otherwise port 0 has priority.
module fmrv32im_rr_arbiter
  import fmrv32im_axi_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef FMRV32IM_AXI_ARB_RR_EN
  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant = last_grant ? 2'b01 : 2'b10;
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      default:        grant = 2'b00;
    endcase
  end
`else
  logic unused_last_grant;

  assign unused_last_grant = last_grant;
  assign grant[0] = req[0];
  assign grant[1] = req[1] & ~req[0];
`endif

endmodule

// File: rtl/fmrv32im_axi_arbiter.sv
// Arbitrates the instruction and data ports onto one single-beat AXI4 master.
// Build option: FMRV32IM_AXI_ARB_RR_EN enables round-robin grant.
module fmrv32im_axi_arbiter
  import fmrv32im_axi_arb_pkg::*;
#(
  parameter logic AXI_ID = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_we,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_wdata,
  input  logic [1:0][3:0]  req_wstb,
  output logic [1:0]       req_ready,
  output logic [31:0]      req_rdata,
  output logic             req_err,
  output logic             MM_AXI_AWID,
  output logic [31:0]      MM_AXI_AWADDR,
  output logic [7:0]       MM_AXI_AWLEN,
  output logic [2:0]       MM_AXI_AWSIZE,
  output logic [1:0]       MM_AXI_AWBURST,
  output logic             MM_AXI_AWLOCK,
  output logic [3:0]       MM_AXI_AWCACHE,
  output logic [2:0]       MM_AXI_AWPROT,
  output logic [3:0]       MM_AXI_AWQOS,
  output logic             MM_AXI_AWUSER,
  output logic             MM_AXI_AWVALID,
  input  logic             MM_AXI_AWREADY,
  output logic [31:0]      MM_AXI_WDATA,
  output logic [3:0]       MM_AXI_WSTRB,
  output logic             MM_AXI_WLAST,
  output logic             MM_AXI_WUSER,
  output logic             MM_AXI_WVALID,
  input  logic             MM_AXI_WREADY,
  input  logic             MM_AXI_BID,
  input  logic [1:0]       MM_AXI_BRESP,
  input  logic             MM_AXI_BUSER,
  input  logic             MM_AXI_BVALID,
  output logic             MM_AXI_BREADY,
  output logic             MM_AXI_ARID,
  output logic [31:0]      MM_AXI_ARADDR,
  output logic [7:0]       MM_AXI_ARLEN,
  output logic [2:0]       MM_AXI_ARSIZE,
  output logic [1:0]       MM_AXI_ARBURST,
  output logic [1:0]       MM_AXI_ARLOCK,
  output logic [3:0]       MM_AXI_ARCACHE,
  output logic [2:0]       MM_AXI_ARPROT,
  output logic [3:0]       MM_AXI_ARQOS,
  output logic             MM_AXI_ARUSER,
  output logic             MM_AXI_ARVALID,
  input  logic             MM_AXI_ARREADY,
  input  logic             MM_AXI_RID,
  input  logic [31:0]      MM_AXI_RDATA,
  input  logic [1:0]       MM_AXI_RRESP,
  input  logic             MM_AXI_RLAST,
  input  logic             MM_AXI_RUSER,
  input  logic             MM_AXI_RVALID,
  output logic             MM_AXI_RREADY
);

  state_t      state, state_n;
  logic [1:0]  grant;
  logic        gidx;
  logic        grant_q;
  logic        last_grant;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstb_q;
  logic        aw_done;
  logic        w_done;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        unused_in;

  fmrv32im_rr_arbiter u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign gidx = grant[1];

  assign unused_in = ^{MM_AXI_BID, MM_AXI_BUSER, MM_AXI_RID,
                       MM_AXI_RUSER, MM_AXI_RLAST, we_q};

  assign MM_AXI_AWID    = AXI_ID;
  assign MM_AXI_AWADDR  = addr_q;
  assign MM_AXI_AWLEN   = 8'd0;
  assign MM_AXI_AWSIZE  = AXI_SIZE_WORD;
  assign MM_AXI_AWBURST = AXI_BURST_INCR;
  assign MM_AXI_AWLOCK  = 1'b0;
  assign MM_AXI_AWCACHE = AXI_CACHE_DEF;
  assign MM_AXI_AWPROT  = 3'd0;
  assign MM_AXI_AWQOS   = 4'd0;
  assign MM_AXI_AWUSER  = 1'b0;
  assign MM_AXI_WDATA   = wdata_q;
  assign MM_AXI_WSTRB   = wstb_q;
  assign MM_AXI_WLAST   = 1'b1;
  assign MM_AXI_WUSER   = 1'b0;
  assign MM_AXI_ARID    = AXI_ID;
  assign MM_AXI_ARADDR  = addr_q;
  assign MM_AXI_ARLEN   = 8'd0;
  assign MM_AXI_ARSIZE  = AXI_SIZE_WORD;
  assign MM_AXI_ARBURST = AXI_BURST_INCR;
  assign MM_AXI_ARLOCK  = 2'b00;
  assign MM_AXI_ARCACHE = AXI_CACHE_DEF;
  assign MM_AXI_ARPROT  = 3'd0;
  assign MM_AXI_ARQOS   = 4'd0;
  assign MM_AXI_ARUSER  = 1'b0;
  assign req_rdata      = rdata_q;
  assign req_err        = err_q;

  always_comb begin
    state_n        = state;
    MM_AXI_ARVALID = 1'b0;
    MM_AXI_RREADY  = 1'b0;
    MM_AXI_AWVALID = 1'b0;
    MM_AXI_WVALID  = 1'b0;
    MM_AXI_BREADY  = 1'b0;
    req_ready      = 2'b00;
    unique case (state)
      IDLE: begin
        if (|req_valid)
          state_n = req_we[gidx] ? WADDR : RADDR;
      end
      RADDR: begin
        MM_AXI_ARVALID = 1'b1;
        if (MM_AXI_ARREADY) state_n = RDATA;
      end
      RDATA: begin
        MM_AXI_RREADY = 1'b1;
        if (MM_AXI_RVALID) state_n = DONE;
      end
      WADDR: begin
        MM_AXI_AWVALID = ~aw_done;
        MM_AXI_WVALID  = ~w_done;
        // both channels may finish in the same cycle
        if ((aw_done | MM_AXI_AWREADY) &&
            (w_done | MM_AXI_WREADY))
          state_n = WRESP;
      end
      WRESP: begin
        MM_AXI_BREADY = 1'b1;
        if (MM_AXI_BVALID) state_n = DONE;
      end
      DONE: begin
        req_ready[grant_q] = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wstb_q     <= 4'd0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && |req_valid) begin
        grant_q    <= gidx;
        last_grant <= gidx;
        we_q       <= req_we[gidx];
        addr_q     <= req_addr[gidx];
        wdata_q    <= req_wdata[gidx];
        wstb_q     <= req_wstb[gidx];
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
      end
      if (state == WADDR) begin
        if (MM_AXI_AWREADY) aw_done <= 1'b1;
        if (MM_AXI_WREADY)  w_done  <= 1'b1;
      end
      if (state == RDATA && MM_AXI_RVALID) begin
        rdata_q <= MM_AXI_RDATA;
        err_q   <= (MM_AXI_RRESP != AXI_RESP_OKAY);
      end
      if (state == WRESP && MM_AXI_BVALID)
        err_q <= (MM_AXI_BRESP != AXI_RESP_OKAY);
    end
  end

endmodule
